// File: rtl/ddr_channel_arbiter.sv
// Three-way DDR command arbiter: store > load > fetch fixed priority, with a
// starvation guard that forces a fetch grant after STARVE_LIMIT lost grants.
module ddr_channel_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,

    input  logic         pc_index_valid,
    input  logic [18:0]  pc_index,
    output logic         pc_index_ready,
    output logic [511:0] pc_read_inst,
    output logic         pc_operation_done,

    input  logic         opload_index_valid,
    input  logic [18:0]  opload_index,
    output logic         opload_index_ready,
    output logic [63:0]  opload_read_data,
    output logic         opload_operation_done,

    input  logic         opstore_index_valid,
    input  logic [18:0]  opstore_index,
    input  logic [63:0]  opstore_write_mask,
    input  logic [63:0]  opstore_write_data,
    output logic         opstore_index_ready,
    output logic         opstore_operation_done,

    output logic         ddr_chip_enable,
    output logic [18:0]  ddr_index,
    output logic         ddr_write_enable,
    output logic         ddr_burst_mode,
    output logic [63:0]  ddr_opstore_write_mask,
    output logic [63:0]  ddr_opstore_write_data,
    input  logic [63:0]  ddr_opload_read_data,
    input  logic [511:0] ddr_pc_read_inst,
    input  logic         ddr_operation_done,
    input  logic         ddr_ready
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
    typedef enum logic [1:0] {CH_NONE, CH_PC, CH_LOAD, CH_STORE} chan_e;

    state_e       state_q, state_d;
    chan_e        chan_q, chan_d;
    chan_e        winner;
    logic [3:0]   starve_q, starve_d;
    logic [18:0]  index_q, index_d;
    logic [63:0]  mask_q, mask_d;
    logic [63:0]  wdata_q, wdata_d;
    logic         chip_enable_q, chip_enable_d;
    logic         write_enable_q, write_enable_d;
    logic         burst_q, burst_d;
    logic         pc_done_q, pc_done_d;
    logic         load_done_q, load_done_d;
    logic         store_done_q, store_done_d;
    logic [511:0] pc_data_q, pc_data_d;
    logic [63:0]  load_data_q, load_data_d;

    // Ready is combinational so the requester sees the accept in the same cycle.
    always_comb begin : arbitrate
        winner = CH_NONE;
        if (!reset && state_q == ST_IDLE && ddr_ready) begin
            if (pc_index_valid && starve_q == STARVE_MAX) winner = CH_PC;
            else if (opstore_index_valid)                 winner = CH_STORE;
            else if (opload_index_valid)                  winner = CH_LOAD;
            else if (pc_index_valid)                      winner = CH_PC;
        end
    end

    assign pc_index_ready      = (winner == CH_PC);
    assign opload_index_ready  = (winner == CH_LOAD);
    assign opstore_index_ready = (winner == CH_STORE);

    always_comb begin : next_state
        // NOTE: every _d defaults to its _q (or to 0 for pulses) so no path infers a latch.
        state_d        = state_q;
        chan_d         = chan_q;
        starve_d       = starve_q;
        index_d        = index_q;
        mask_d         = mask_q;
        wdata_d        = wdata_q;
        write_enable_d = write_enable_q;
        burst_d        = burst_q;
        pc_data_d      = pc_data_q;
        load_data_d    = load_data_q;
        chip_enable_d  = 1'b0;
        pc_done_d      = 1'b0;
        load_done_d    = 1'b0;
        store_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (winner != CH_NONE) begin
                    state_d        = ST_ISSUE;
                    chan_d         = winner;
                    chip_enable_d  = 1'b1;
                    write_enable_d = (winner == CH_STORE);
                    burst_d        = (winner == CH_PC);
                    case (winner)
                        CH_PC: begin
                            index_d  = pc_index;
                            starve_d = '0;
                        end
                        CH_LOAD: index_d = opload_index;
                        default: begin
                            index_d = opstore_index;
                            mask_d  = opstore_write_mask;
                            wdata_d = opstore_write_data;
                        end
                    endcase
                    // A waiting fetch that lost this grant moves closer to forced service.
                    if (winner != CH_PC && pc_index_valid && starve_q != STARVE_MAX)
                        starve_d = starve_q + 4'd1;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (ddr_operation_done) begin
                    state_d        = ST_RESP;
                    write_enable_d = 1'b0;
                    burst_d        = 1'b0;
                    pc_done_d      = (chan_q == CH_PC);
                    load_done_d    = (chan_q == CH_LOAD);
                    store_done_d   = (chan_q == CH_STORE);
                    if (chan_q == CH_PC)   pc_data_d   = ddr_pc_read_inst;
                    if (chan_q == CH_LOAD) load_data_d = ddr_opload_read_data;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only; data registers are reset because reset must clear them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            chan_q         <= CH_NONE;
            starve_q       <= '0;
            index_q        <= '0;
            mask_q         <= '0;
            wdata_q        <= '0;
            chip_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            burst_q        <= 1'b0;
            pc_done_q      <= 1'b0;
            load_done_q    <= 1'b0;
            store_done_q   <= 1'b0;
            pc_data_q      <= '0;
            load_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            starve_q       <= starve_d;
            index_q        <= index_d;
            mask_q         <= mask_d;
            wdata_q        <= wdata_d;
            chip_enable_q  <= chip_enable_d;
            write_enable_q <= write_enable_d;
            burst_q        <= burst_d;
            pc_done_q      <= pc_done_d;
            load_done_q    <= load_done_d;
            store_done_q   <= store_done_d;
            pc_data_q      <= pc_data_d;
            load_data_q    <= load_data_d;
        end
    end

    assign ddr_chip_enable        = chip_enable_q;
    assign ddr_index              = index_q;
    assign ddr_write_enable       = write_enable_q;
    assign ddr_burst_mode         = burst_q;
    assign ddr_opstore_write_mask = mask_q;
    assign ddr_opstore_write_data = wdata_q;
    assign pc_operation_done      = pc_done_q;
    assign opload_operation_done  = load_done_q;
    assign opstore_operation_done = store_done_q;
    assign pc_read_inst           = pc_data_q;
    assign opload_read_data       = load_data_q;

endmodule

// File: tb/tb_ddr_channel_arbiter.sv
// Scoreboard bench for ddr_channel_arbiter: a transaction-level model predicts
// grants and timing; separate monitors compare DDR commands and channel responses.
module tb_ddr_channel_arbiter;

    localparam int STARVE = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         pc_index_valid, opload_index_valid, opstore_index_valid;
    logic [18:0]  pc_index, opload_index, opstore_index;
    logic [63:0]  opstore_write_mask, opstore_write_data;
    logic         pc_index_ready, opload_index_ready, opstore_index_ready;
    logic [511:0] pc_read_inst;
    logic [63:0]  opload_read_data;
    logic         pc_operation_done, opload_operation_done, opstore_operation_done;
    logic         ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
    logic [18:0]  ddr_index;
    logic [63:0]  ddr_opstore_write_mask, ddr_opstore_write_data;
    logic [63:0]  ddr_opload_read_data;
    logic [511:0] ddr_pc_read_inst;
    logic         ddr_operation_done, ddr_ready;

    ddr_channel_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clock(clock), .reset(reset),
        .pc_index_valid(pc_index_valid), .pc_index(pc_index),
        .pc_index_ready(pc_index_ready), .pc_read_inst(pc_read_inst),
        .pc_operation_done(pc_operation_done),
        .opload_index_valid(opload_index_valid), .opload_index(opload_index),
        .opload_index_ready(opload_index_ready), .opload_read_data(opload_read_data),
        .opload_operation_done(opload_operation_done),
        .opstore_index_valid(opstore_index_valid), .opstore_index(opstore_index),
        .opstore_write_mask(opstore_write_mask), .opstore_write_data(opstore_write_data),
        .opstore_index_ready(opstore_index_ready),
        .opstore_operation_done(opstore_operation_done),
        .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
        .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_opstore_write_mask(ddr_opstore_write_mask),
        .ddr_opstore_write_data(ddr_opstore_write_data),
        .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
        .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel ids: 1 = fetch, 2 = load, 3 = store; vectors are {store, load, pc}.
    function automatic logic [2:0] onehot(input int ch);
        return (ch == 0) ? 3'b000 : 3'(1 << (ch - 1));
    endfunction

    function automatic int chan_of(input logic [2:0] v);
        if (v[2]) return 3;
        if (v[1]) return 2;
        if (v[0]) return 1;
        return 0;
    endfunction

    function automatic int pick(input bit pv, input bit lv, input bit sv, input int starve);
        if (pv && starve == STARVE) return 1;
        if (sv) return 3;
        if (lv) return 2;
        if (pv) return 1;
        return 0;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    typedef struct {
        int          ch;
        logic [18:0] idx;
        logic [63:0] mask;
        logic [63:0] data;
    } cmd_t;

    typedef struct {
        int           ch;
        logic [511:0] data;
    } resp_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    int    grant_log[$];
    int    acc_cyc[$];
    int    done_cyc[$];

    // Transaction-level reference state.
    int           cyc = 0;
    int           m_out = 0;
    bit           m_issue = 0;
    int           m_resp = 0;
    int           m_starve = 0;
    int           m_win;
    logic [511:0] m_pc = '0;
    logic [63:0]  m_load = '0;
    logic [2:0]   act_rdy, act_done;

    always @(negedge clock) begin : model
        cyc++;
        act_rdy  = {opstore_index_ready, opload_index_ready, pc_index_ready};
        act_done = {opstore_operation_done, opload_operation_done, pc_operation_done};
        if (reset) begin
            check("reset_outputs", {act_rdy, act_done, ddr_chip_enable, ddr_write_enable,
                  ddr_burst_mode, ddr_index, ddr_opstore_write_mask, ddr_opstore_write_data,
                  opload_read_data}, '0);
            check("reset_pc_data", pc_read_inst, '0);
            m_out = 0; m_issue = 0; m_resp = 0; m_starve = 0; m_pc = '0; m_load = '0;
            cmd_q.delete();
            resp_q.delete();
        end else begin
            m_win = (m_out == 0 && m_resp == 0 && ddr_ready) ?
                    pick(pc_index_valid, opload_index_valid, opstore_index_valid, m_starve) : 0;
            check("ready_vector", act_rdy, onehot(m_win));
            check("chip_enable", ddr_chip_enable, m_issue);
            check("we_burst", {ddr_write_enable, ddr_burst_mode}, {m_out == 3, m_out == 1});
            check("done_vector", act_done, onehot(m_resp));
            check("pc_data_hold", pc_read_inst, m_pc);
            check("load_data_hold", opload_read_data, m_load);
            if (act_rdy != 3'b000) begin
                grant_log.push_back(chan_of(act_rdy));
                acc_cyc.push_back(cyc);
            end
            if (act_done != 3'b000) done_cyc.push_back(cyc);

            m_issue = (m_win != 0);
            m_resp  = 0;
            if (m_out != 0 && ddr_operation_done) begin
                m_resp = m_out;
                if (m_out == 1) m_pc = ddr_pc_read_inst;
                if (m_out == 2) m_load = ddr_opload_read_data;
                resp_q.push_back('{ch: m_out,
                                   data: (m_out == 1) ? ddr_pc_read_inst : 512'(ddr_opload_read_data)});
                m_out = 0;
            end
            if (m_win != 0) begin
                cmd_q.push_back('{ch: m_win,
                                  idx: (m_win == 1) ? pc_index : (m_win == 2) ? opload_index : opstore_index,
                                  mask: opstore_write_mask, data: opstore_write_data});
                if (m_win == 1) m_starve = 0;
                else if (pc_index_valid && m_starve < STARVE) m_starve++;
                m_out = m_win;
            end
        end
    end

    cmd_t  sb_cmd;
    resp_t sb_resp;

    always @(negedge clock) begin : scoreboard
        if (!reset) begin
            if (ddr_chip_enable) begin
                check("cmd_pending", cmd_q.size() != 0, 1'b1);
                if (cmd_q.size() != 0) begin
                    sb_cmd = cmd_q.pop_front();
                    check("cmd_index", ddr_index, sb_cmd.idx);
                    if (sb_cmd.ch == 3) begin
                        check("cmd_mask", ddr_opstore_write_mask, sb_cmd.mask);
                        check("cmd_data", ddr_opstore_write_data, sb_cmd.data);
                    end
                end
            end
            if ({opstore_operation_done, opload_operation_done, pc_operation_done} != 3'b000) begin
                check("resp_pending", resp_q.size() != 0, 1'b1);
                if (resp_q.size() != 0) begin
                    sb_resp = resp_q.pop_front();
                    check("resp_channel", {opstore_operation_done, opload_operation_done,
                          pc_operation_done}, onehot(sb_resp.ch));
                    if (sb_resp.ch == 2) check("resp_load_data", opload_read_data, sb_resp.data[63:0]);
                    if (sb_resp.ch == 1) check("resp_pc_data", pc_read_inst, sb_resp.data);
                end
            end
        end
    end

    // Stimulus knobs.
    int unsigned rate_pc = 0, rate_ld = 0, rate_st = 0, cancel_rate = 0;
    int unsigned rdy_rate = 100, stray_rate = 0, lat_min = 0, lat_max = 0;
    bit          keep_ld = 0, fix_load = 0;
    logic [63:0] fix_load_val = 64'h0123456789ABCDEF;
    logic [2:0]  drv_acc;
    bit          ddr_busy = 0;
    int unsigned ddr_cd = 0;

    task automatic clear_logs();
        grant_log.delete();
        acc_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic step();
        @(negedge clock);
        drv_acc = reset ? 3'b000 : {opstore_index_ready, opload_index_ready, pc_index_ready};
        if (drv_acc != 3'b000) begin
            ddr_busy = 1'b1;
            ddr_cd   = $urandom_range(lat_max, lat_min);
        end
        @(posedge clock);
        #1;
        ddr_opload_read_data = fix_load ? fix_load_val : {$urandom, $urandom};
        ddr_pc_read_inst     = rand512();
        ddr_operation_done   = 1'b0;
        if (ddr_busy) begin
            if (ddr_cd == 0) begin
                ddr_operation_done = 1'b1;
                ddr_busy           = 1'b0;
            end else begin
                ddr_cd--;
            end
        end else if ($urandom_range(0, 99) < stray_rate) begin
            ddr_operation_done = 1'b1;
        end
        ddr_ready = ($urandom_range(0, 99) < rdy_rate);

        if (drv_acc[0]) pc_index_valid = 1'b0;
        else if (pc_index_valid && $urandom_range(0, 99) < cancel_rate) pc_index_valid = 1'b0;
        if (!pc_index_valid && $urandom_range(0, 99) < rate_pc) begin
            pc_index_valid = 1'b1;
            pc_index       = 19'($urandom);
        end

        if (drv_acc[1] && keep_ld) opload_index = 19'($urandom);
        else if (drv_acc[1]) opload_index_valid = 1'b0;
        else if (opload_index_valid && $urandom_range(0, 99) < cancel_rate) opload_index_valid = 1'b0;
        if (!opload_index_valid && $urandom_range(0, 99) < rate_ld) begin
            opload_index_valid = 1'b1;
            opload_index       = 19'($urandom);
        end

        if (drv_acc[2]) opstore_index_valid = 1'b0;
        else if (opstore_index_valid && $urandom_range(0, 99) < cancel_rate) opstore_index_valid = 1'b0;
        if (!opstore_index_valid && $urandom_range(0, 99) < rate_st) begin
            opstore_index_valid = 1'b1;
            opstore_index       = 19'($urandom);
            opstore_write_mask  = {$urandom, $urandom};
            opstore_write_data  = {$urandom, $urandom};
        end
    endtask

    initial begin
        reset = 1'b1;
        pc_index_valid = 0; opload_index_valid = 0; opstore_index_valid = 0;
        pc_index = '0; opload_index = '0; opstore_index = '0;
        opstore_write_mask = '0; opstore_write_data = '0;
        ddr_opload_read_data = '0; ddr_pc_read_inst = '0;
        ddr_operation_done = 0; ddr_ready = 1;
        repeat (2) step();
        reset = 1'b0;

        // Single store, DDR done two cycles after the strobe.
        lat_min = 2; lat_max = 2;
        clear_logs();
        opstore_index_valid = 1'b1;
        opstore_index       = 19'h00010;
        opstore_write_mask  = 64'hFF;
        opstore_write_data  = 64'hDEADBEEF;
        repeat (6) step();
        check("t1_grants", grant_log.size(), 1);
        check("t1_grant_ch", qget(grant_log, 0), 3);
        check("t1_done_latency", qget(done_cyc, 0) - qget(acc_cyc, 0), 4);

        // Load at the top index with a known DDR word.
        lat_min = 1; lat_max = 1;
        fix_load = 1'b1;
        clear_logs();
        opload_index_valid = 1'b1;
        opload_index       = 19'h7FFFF;
        repeat (6) step();
        fix_load = 1'b0;
        check("t2_grant_ch", qget(grant_log, 0), 2);
        check("t2_load_data", opload_read_data, 64'h0123456789ABCDEF);
        check("t2_pc_untouched", pc_read_inst, '0);

        // All three at once: store, load, then fetch.
        clear_logs();
        pc_index_valid = 1'b1;      pc_index = 19'h00123;
        opload_index_valid = 1'b1;  opload_index = 19'h00456;
        opstore_index_valid = 1'b1; opstore_index = 19'h00789;
        opstore_write_mask = 64'h0F0F; opstore_write_data = 64'h1122334455667788;
        repeat (14) step();
        check("t3_grants", grant_log.size(), 3);
        check("t3_first", qget(grant_log, 0), 3);
        check("t3_second", qget(grant_log, 1), 2);
        check("t3_third", qget(grant_log, 2), 1);
        for (int i = 0; i < 2; i++)
            check("t3_done_before_next", qget(done_cyc, i) < qget(acc_cyc, i + 1), 1'b1);

        // Continuous load with fetch waiting: fetch forced in every fifth grant.
        lat_min = 0; lat_max = 0;
        clear_logs();
        keep_ld = 1'b1; rate_pc = 100;
        opload_index_valid = 1'b1; opload_index = 19'h00321;
        pc_index_valid = 1'b1;     pc_index = 19'h00654;
        repeat (31) step();
        for (int i = 0; i < 10; i++)
            check("t4_starve_pattern", qget(grant_log, i), (i % 5 == 4) ? 1 : 2);
        keep_ld = 1'b0; rate_pc = 0;
        repeat (8) step();

        // DDR not ready: requests wait.
        rdy_rate = 0;
        step();
        clear_logs();
        opstore_index_valid = 1'b1; opstore_index = 19'h0ABCD;
        repeat (5) step();
        check("t5_no_grant_while_busy", grant_log.size(), 0);
        rdy_rate = 100;
        repeat (6) step();
        check("t5_grant_after_ready", grant_log.size(), 1);

        // Reset during WAIT, then a stale done pulse.
        lat_min = 3; lat_max = 3;
        opload_index_valid = 1'b1; opload_index = 19'h12345;
        step();
        step();
        reset = 1'b1;
        #1;
        check("t6_async_reset", {ddr_chip_enable, ddr_write_enable, ddr_burst_mode,
              ddr_index, opload_read_data}, '0);
        clear_logs();
        step();
        reset = 1'b0;
        repeat (4) step();
        check("t6_no_done_after_reset", done_cyc.size(), 0);
        lat_min = 1; lat_max = 1;
        pc_index_valid = 1'b1; pc_index = 19'h0FACE;
        repeat (6) step();
        check("t6_next_grant", qget(grant_log, 0), 1);
        check("t6_next_done", done_cyc.size(), 1);

        // Randomized traffic.
        rate_pc = 30; rate_ld = 30; rate_st = 25; cancel_rate = 5;
        rdy_rate = 80; stray_rate = 15; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            keep_ld = ($urandom_range(0, 3) == 0);
            step();
        end

        // Drain.
        rate_pc = 0; rate_ld = 0; rate_st = 0; cancel_rate = 0;
        rdy_rate = 100; stray_rate = 0; keep_ld = 1'b0;
        repeat (30) step();
        check("drain_cmd_q", cmd_q.size(), 0);
        check("drain_resp_q", resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_channel_arbiter.md
# ddr_channel_arbiter

Three-way arbiter between the core's memory request channels (instruction-fetch burst read, 64-bit load, 64-bit masked store) and the single shared DDR port of `simddr`. Sits directly upstream of `simddr` inside the core-side memory path. Grants one channel at a time, issues a single-cycle `ddr_chip_enable` command, waits for `ddr_operation_done`, and returns registered response data with a one-cycle done pulse to the granted channel. Arbitration is fixed priority with a starvation guard for instruction fetch.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive lost grants after which a waiting pc request wins regardless of priority (1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pc_index_valid  in  1  fetch request; held with payload until accepted
- pc_index  in  19  fetch line index
- pc_index_ready  out  1  one-cycle accept pulse for fetch
- pc_read_inst  out  512  registered fetch line
- pc_operation_done  out  1  one-cycle pulse; pc_read_inst valid
- opload_index_valid / opload_index  in  1 / 19  load request and index
- opload_index_ready  out  1  load accept pulse
- opload_read_data  out  64  registered load data
- opload_operation_done  out  1  load done pulse
- opstore_index_valid / opstore_index  in  1 / 19  store request and index
- opstore_write_mask / opstore_write_data  in  64 / 64  store payload
- opstore_index_ready  out  1  store accept pulse
- opstore_operation_done  out  1  store done pulse
- ddr_chip_enable  out  1  one-cycle command strobe
- ddr_index  out  19  command index
- ddr_write_enable  out  1  1 = store
- ddr_burst_mode  out  1  1 = fetch (512-bit burst)
- ddr_opstore_write_mask / ddr_opstore_write_data  out  64 / 64  store payload
- ddr_opload_read_data  in  64  DDR load data
- ddr_pc_read_inst  in  512  DDR burst data
- ddr_operation_done  in  1  DDR completion pulse
- ddr_ready  in  1  DDR can accept a command

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if ddr_ready=1 and any valid, select winner: pc if starve_cnt==STARVE_LIMIT and pc valid; else store > load > pc. Winner's `*_index_ready`=1 (combinational, same cycle); payload and channel id registered; go ISSUE. No valid or ddr_ready=0: stay, no ready.
- ISSUE: ddr_chip_enable=1 for exactly this cycle; go WAIT.
- ddr_index, ddr_write_enable, ddr_burst_mode, mask, data driven from registered payload during ISSUE and WAIT; write_enable/burst_mode forced 0 in IDLE and RESP; index/mask/data hold last issued value.
- ISSUE/WAIT: ddr_operation_done=1 captures ddr_opload_read_data (load) or ddr_pc_read_inst (pc) into that channel's data register; go RESP. Done in ISSUE is accepted identically.
- RESP: granted channel's `*_operation_done`=1 for one cycle; go IDLE. Store returns no data.
- Data registers change only on their own channel's completion; hold otherwise.
- starve_cnt: on a store/load grant with pc_index_valid=1, increment, saturating at STARVE_LIMIT; clear on pc grant; otherwise hold.
- ddr_operation_done in IDLE or RESP is ignored.

## Timing
- Reset (async, immediate): FSM IDLE, starve_cnt 0, all outputs 0, all data registers 0.
- Reset mid-operation: transaction dropped, no done pulse; stale ddr_operation_done after reset ignored.
- Accept at T, chip_enable at T+1, earliest done-in at T+1, channel done at T+2, next accept at T+3. Minimum 3 cycles per transaction; no pipelining.
- At most one `*_index_ready` and one `*_operation_done` high in any cycle.
- Requester must hold valid/payload stable until ready; dropping valid before ready cancels cleanly.

## Test plan
- Reset then store idx 0x00010, mask 0xFF, data 0xDEADBEEF, ddr_ready=1, done 2 cycles after chip_enable -> ready at T, chip_enable+write_enable at T+1, opstore_operation_done at T+4, others silent.
- Load idx 0x7FFFF, DDR returns 0x0123456789ABCDEF -> opload_read_data equals it in done cycle; pc_read_inst unchanged.
- Store, load, pc valid together -> grant order store, load, pc; each done pulse precedes next ready.
- Load held continuously, pc valid, STARVE_LIMIT=4 -> 4 load grants, 5th grant pc with ddr_burst_mode=1; starve_cnt back to 0.
- ddr_ready=0 with requests pending -> no ready, no chip_enable until ddr_ready=1.
- Reset asserted during WAIT, then done pulse -> all outputs 0, no operation_done, next request served normally.
